// File: rtl/spi_ram_arbiter.sv
// Two-requester arbiter in front of the single-port command RAM. An address
// command locks the RAM to its requester until the matching data command or
// read response, so address/data pairs from the two sides never interleave.
module spi_ram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [9:0] req0_data,
    output logic       req0_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       req1_valid,
    input  logic [9:0] req1_data,
    output logic       req1_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    output logic       ram_rx_valid,
    output logic [9:0] ram_din,
    input  logic       ram_tx_valid,
    input  logic [7:0] ram_dout,
    output logic       owner,
    output logic       locked,
    output logic       timeout_evt
);

    localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWrLock, StRdLock, StRdWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic            evt_q, evt_d;
    logic            rx_valid_q, rx_valid_d;
    logic [9:0]      din_q, din_d;
    logic            rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [7:0]      rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic            acc0, acc1, acc;
    logic [9:0]      acc_data;

    // Grant: round robin in idle, owner-only while locked, nobody in RD_WAIT.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    req0_ready = req0_valid && (!req1_valid || !ptr_q);
                    req1_ready = req1_valid && (!req0_valid || ptr_q);
                end
                StWrLock, StRdLock: begin
                    req0_ready = req0_valid && !owner_q;
                    req1_ready = req1_valid && owner_q;
                end
                default: ;
            endcase
        end
    end

    assign acc0     = req0_valid && req0_ready;
    assign acc1     = req1_valid && req1_ready;
    assign acc      = acc0 || acc1;
    assign acc_data = acc1 ? req1_data : req0_data;

    // Next state: accepted command first, then read response, then timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        evt_d        = 1'b0;
        rx_valid_d   = 1'b0;
        din_d        = din_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        if (acc) begin
            rx_valid_d = 1'b1;
            din_d      = acc_data;
            cnt_d      = '0;
            unique case (acc_data[9:8])
                2'b00:   state_d = StWrLock;
                2'b01:   state_d = StIdle;
                2'b10:   state_d = StRdLock;
                default: state_d = StRdWait;
            endcase
            if (state_q == StIdle) begin
                owner_d = acc1;
                ptr_d   = !acc1;
            end
        end else if (state_q == StRdWait && ram_tx_valid) begin
            // Response beats a coincident timeout.
            state_d = StIdle;
            cnt_d   = '0;
            if (owner_q) begin
                rsp1_valid_d = 1'b1;
                rsp1_data_d  = ram_dout;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_data_d  = ram_dout;
            end
        end else if (state_q != StIdle) begin
            if (cnt_q == CntLast) begin
                state_d = StIdle;
                evt_d   = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            ptr_q        <= 1'b0;
            evt_q        <= 1'b0;
            rx_valid_q   <= 1'b0;
            din_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            evt_q        <= evt_d;
            rx_valid_q   <= rx_valid_d;
            din_q        <= din_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign ram_rx_valid = rx_valid_q;
    assign ram_din      = din_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_data    = rsp1_data_q;
    assign owner        = owner_q;
    assign locked       = (state_q != StIdle);
    assign timeout_evt  = evt_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: behavioural RAM, scoreboard of RAM commands and
// responses, and one task per scenario.
`timescale 1ns/1ps
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [9:0] req0_data = '0, req1_data = '0;
    logic       req0_ready, req1_ready;
    logic       rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic       ram_rx_valid;
    logic [9:0] ram_din;
    logic       ram_tx_valid = 1'b0;
    logic [7:0] ram_dout = '0;
    logic       owner, locked, timeout_evt;

    int total = 0;
    int bad = 0;
    logic [9:0] exp_cmd[$];
    logic [7:0] exp_rsp0[$];
    logic [7:0] exp_rsp1[$];

    always #5 clk = ~clk;

    spi_ram_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_rx_valid(ram_rx_valid), .ram_din(ram_din),
        .ram_tx_valid(ram_tx_valid), .ram_dout(ram_dout),
        .owner(owner), .locked(locked), .timeout_evt(timeout_evt)
    );

    // Behavioural RAM: stateful address registers, read data one cycle after 11.
    logic [7:0] mem[256];
    logic [7:0] wr_addr = '0, rd_addr = '0;
    always @(posedge clk) begin
        ram_tx_valid <= 1'b0;
        if (ram_rx_valid === 1'b1) begin
            case (ram_din[9:8])
                2'b00: wr_addr <= ram_din[7:0];
                2'b01: mem[wr_addr] <= ram_din[7:0];
                2'b10: rd_addr <= ram_din[7:0];
                default: begin
                    ram_tx_valid <= 1'b1;
                    ram_dout     <= mem[rd_addr];
                end
            endcase
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_rx_valid === 1'b1) begin
            total++;
            if (exp_cmd.size() == 0) begin
                bad++;
                $display("FAIL ram_cmd unexpected: got %h, none expected", ram_din);
            end else begin
                automatic logic [9:0] e = exp_cmd.pop_front();
                if (ram_din !== e) begin
                    bad++;
                    $display("FAIL ram_cmd: got %h want %h", ram_din, e);
                end
            end
        end
        if (rsp0_valid === 1'b1) begin
            total++;
            if (exp_rsp0.size() == 0) begin
                bad++;
                $display("FAIL rsp0 unexpected: got %h, none expected", rsp0_data);
            end else begin
                automatic logic [7:0] e = exp_rsp0.pop_front();
                if (rsp0_data !== e) begin
                    bad++;
                    $display("FAIL rsp0_data: got %h want %h", rsp0_data, e);
                end
            end
        end
        if (rsp1_valid === 1'b1) begin
            total++;
            if (exp_rsp1.size() == 0) begin
                bad++;
                $display("FAIL rsp1 unexpected: got %h, none expected", rsp1_data);
            end else begin
                automatic logic [7:0] e = exp_rsp1.pop_front();
                if (rsp1_data !== e) begin
                    bad++;
                    $display("FAIL rsp1_data: got %h want %h", rsp1_data, e);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one command and wait (bounded) for it to be accepted.
    task automatic send(input int r, input logic [9:0] d);
        int n = 0;
        @(negedge clk);
        if (r == 0) begin req0_valid = 1'b1; req0_data = d; end
        else        begin req1_valid = 1'b1; req1_data = d; end
        #1;
        while (!(r == 0 ? req0_ready : req1_ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send req%0d cmd %h: ready never seen, want accept", r, d);
        end else begin
            @(posedge clk);
            exp_cmd.push_back(d);
            #1;
        end
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        total++;
        if ({owner, locked, timeout_evt, ram_rx_valid, ram_din, rsp0_valid, rsp1_valid,
             rsp0_data, rsp1_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got o=%b l=%b t=%b rx=%b din=%h r0=%b/%h r1=%b/%h want 0",
                     owner, locked, timeout_evt, ram_rx_valid, ram_din, rsp0_valid, rsp0_data,
                     rsp1_valid, rsp1_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write();
        send(0, 10'h005);
        total++;
        if (locked !== 1'b1 || owner !== 1'b0) begin
            bad++;
            $display("FAIL write_lock: got locked=%b owner=%b want 1/0", locked, owner);
        end
        send(0, 10'h1A5);
        total++;
        if (locked !== 1'b0 || ram_rx_valid !== 1'b1) begin
            bad++;
            $display("FAIL write_done: got locked=%b rx=%b want 0/1", locked, ram_rx_valid);
        end
    endtask

    task automatic test_read();
        send(1, 10'h205);
        send(1, 10'h300);
        exp_rsp1.push_back(8'hA5);
        for (int k = 1; k <= 2; k++) begin
            total++;
            if (rsp1_valid !== 1'b0) begin
                bad++;
                $display("FAIL read_latency cycle N+%0d: got rsp1_valid=%b want 0", k, rsp1_valid);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 8'hA5 || locked !== 1'b0) begin
            bad++;
            $display("FAIL read_rsp N+3: got v=%b d=%h locked=%b want 1/a5/0",
                     rsp1_valid, rsp1_data, locked);
        end
        total++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== 8'h00) begin
            bad++;
            $display("FAIL read_nonowner: got rsp0 v=%b d=%h want 0/00", rsp0_valid, rsp0_data);
        end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 10'h009;
        req1_valid = 1'b1; req1_data = 10'h00A;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL contend_first: got rdy=%b want 10", {req0_ready, req1_ready});
        end
        @(posedge clk);
        exp_cmd.push_back(10'h009);
        #1 req0_data = 10'h1BB;
        total++;
        if ({req0_ready, req1_ready, locked, owner} !== 4'b1010) begin
            bad++;
            $display("FAIL contend_locked: got rdy=%b locked=%b owner=%b want 10/1/0",
                     {req0_ready, req1_ready}, locked, owner);
        end
        @(posedge clk);
        exp_cmd.push_back(10'h1BB);
        #1 req0_valid = 1'b0;
        #1;
        total++;
        if (req1_ready !== 1'b1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL contend_second: got rdy1=%b locked=%b want 1/0", req1_ready, locked);
        end
        @(posedge clk);
        exp_cmd.push_back(10'h00A);
        #1 req1_data = 10'h1CC;
        total++;
        if (owner !== 1'b1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL contend_owner1: got owner=%b locked=%b want 1/1", owner, locked);
        end
        @(posedge clk);
        exp_cmd.push_back(10'h1CC);
        #1 req1_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        send(0, 10'h007);
        send(0, 10'h111);
        req0_valid = 1'b1; req0_data = 10'h122;
        req1_valid = 1'b1; req1_data = 10'h133;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rr_first: got rdy=%b want 01", {req0_ready, req1_ready});
        end
        @(posedge clk);
        exp_cmd.push_back(10'h133);
        #1 req1_data = 10'h144;
        total++;
        if (owner !== 1'b1 || {req0_ready, req1_ready} !== 2'b10) begin
            bad++;
            $display("FAIL rr_second: got owner=%b rdy=%b want 1/10",
                     owner, {req0_ready, req1_ready});
        end
        @(posedge clk);
        exp_cmd.push_back(10'h122);
        #1 req0_valid = 1'b0;
        total++;
        if (owner !== 1'b0) begin
            bad++;
            $display("FAIL rr_owner0: got owner=%b want 0", owner);
        end
        @(posedge clk);
        exp_cmd.push_back(10'h144);
        #1 req1_valid = 1'b0;
    endtask

    task automatic test_timeout();
        send(0, 10'h005);
        req1_valid = 1'b1;
        req1_data  = 10'h1DD;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (timeout_evt !== 1'b0 || req1_ready !== 1'b0 || locked !== 1'b1) begin
                bad++;
                $display("FAIL timeout_wait k=%0d: got evt=%b rdy1=%b locked=%b want 0/0/1",
                         k, timeout_evt, req1_ready, locked);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (timeout_evt !== 1'b1 || locked !== 1'b0 || req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire: got evt=%b locked=%b rdy1=%b want 1/0/1",
                     timeout_evt, locked, req1_ready);
        end
        @(posedge clk);
        exp_cmd.push_back(10'h1DD);
        #1 req1_valid = 1'b0;
        total++;
        if (timeout_evt !== 1'b0 || owner !== 1'b1) begin
            bad++;
            $display("FAIL timeout_after: got evt=%b owner=%b want 0/1", timeout_evt, owner);
        end
    endtask

    task automatic test_reset_rd_wait();
        send(0, 10'h205);
        send(0, 10'h300);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({owner, locked, timeout_evt, ram_rx_valid, ram_din, rsp0_valid, rsp1_valid,
                 rsp0_data, rsp1_data} !== '0) begin
                bad++;
                $display("FAIL rdwait_reset k=%0d: got o=%b l=%b t=%b rx=%b din=%h r0=%b r1=%b want 0",
                         k, owner, locked, timeout_evt, ram_rx_valid, ram_din,
                         rsp0_valid, rsp1_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_round_robin();
        test_timeout();
        test_reset_rd_wait();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_cmd.size() + exp_rsp0.size() + exp_rsp1.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d left want 0/0/0",
                     exp_cmd.size(), exp_rsp0.size(), exp_rsp1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Arbiter that shares the single-port RAM between two command requesters: the SPI slave's 10-bit command stream and a second local requester. RAM address registers are stateful, so the arbiter locks the RAM to one requester from an address command until the matching data command or read response. Without this lock, two requesters' address/data sequences would interleave and corrupt each other. It sits between the requesters and the RAM's `rx_valid`/`din`/`tx_valid`/`dout` port and routes read data back to the lock owner.

## Interface
Parameters:
- `TIMEOUT`, default 255: idle cycles allowed while a lock is held before it is forcibly released. Must be ≥ 1.

Ports:
- `clk`  in  1  the single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 (SPI slave) has a command.
- `req0_data`  in  10  requester 0 command; bits [9:8] are the opcode, bits [7:0] the payload.
- `req0_ready`  out  1  requester 0 command is accepted this cycle.
- `rsp0_valid`  out  1  one-cycle pulse: read data for requester 0.
- `rsp0_data`  out  8  read data for requester 0.
- `req1_valid`, `req1_data`, `req1_ready`, `rsp1_valid`, `rsp1_data`: the same signals for requester 1.
- `ram_rx_valid`  out  1  command strobe to the RAM.
- `ram_din`  out  10  command to the RAM.
- `ram_tx_valid`  in  1  RAM read data valid.
- `ram_dout`  in  8  RAM read data.
- `owner`  out  1  index of the current or last granted requester.
- `locked`  out  1  high in the WR_LOCK, RD_LOCK and RD_WAIT states.
- `timeout_evt`  out  1  one-cycle pulse when a lock is forcibly released.

## Operation
- Opcodes:
  - 00: write address.
  - 01: write data.
  - 10: read address.
  - 11: read data request.
- The RAM returns `tx_valid` and `dout` exactly 1 cycle after it samples an 11 command.
- States: IDLE, WR_LOCK, RD_LOCK, RD_WAIT.
- Acceptance: a command is accepted when `reqX_valid` and `reqX_ready` are both high at a clock edge. The accepted command is registered onto `ram_din`, and `ram_rx_valid` is pulsed high for 1 cycle.
- Next state is set by the opcode of the accepted command, identically from IDLE, WR_LOCK and RD_LOCK:
  - 00 → WR_LOCK
  - 10 → RD_LOCK
  - 01 → IDLE
  - 11 → RD_WAIT
- IDLE:
  - If exactly one requester is valid, it gets `ready`.
  - If both are valid, the requester pointed to by the round-robin pointer wins.
  - On every accept in IDLE: `owner` is set to the winner, and the pointer is set to the other requester.
- WR_LOCK / RD_LOCK: only the owner's `ready` can be high; the other requester's `ready` is 0.
- RD_WAIT: both `ready` are 0. When `ram_tx_valid` is seen:
  - `ram_dout` is registered to `rspX_data` of the owner, with a 1-cycle `rspX_valid` pulse.
  - Next state is IDLE.
- `rsp_data` of the non-owner keeps its previous value, and its `rsp_valid` stays 0.
- `ram_tx_valid` outside RD_WAIT is ignored.
- Timeout counter:
  - Cleared on every state transition and on every accepted command.
  - Increments each cycle in WR_LOCK, RD_LOCK or RD_WAIT when no command is accepted and no response arrives.
  - When it reaches `TIMEOUT`: next state is IDLE, `timeout_evt` pulses for 1 cycle, and the counter clears.
  - Counter width: $clog2(TIMEOUT+1) bits; it never wraps.
- Simultaneous events in RD_WAIT: if `ram_tx_valid` arrives in the same cycle as the timeout, the response wins. Data is delivered and `timeout_evt` stays 0.

## Timing
- Reset (`rst` high at an edge):
  - State → IDLE, counter → 0, round-robin pointer → requester 0.
  - Outputs: `owner` = 0, `locked` = 0, `timeout_evt` = 0, `ram_rx_valid` = 0, `ram_din` = 0, both `rsp_valid` = 0, both `rsp_data` = 0.
  - Both `ready` are 0 while `rst` is high.
  - Reset mid-lock or in RD_WAIT abandons the sequence; a late `ram_tx_valid` is ignored.
- `reqX_ready` is combinational from state, owner, pointer and the valids. It never depends on `reqX_data`.
- Write sequence, command accepted at edge N:
  - `ram_rx_valid` and `ram_din` are high during cycle N+1.
- Read sequence, 11 command accepted at edge N:
  - RAM `tx_valid` is high in cycle N+2.
  - `rspX_valid` is high in cycle N+3, and the state is IDLE in cycle N+3.
  - The earliest next accept is at edge N+3.
- Back-to-back accepts by the owner are allowed every cycle; `ram_rx_valid` may then be high on consecutive cycles.
- `locked` and `owner` are registered and reflect the state after the edge.

## Test plan
- Single write, requester 0: 0x005 then 0x1A5 on consecutive cycles → `ram_din` = 0x005, then 0x1A5 on the next 2 cycles. `locked` = 1 between the two commands, IDLE afterwards.
- Read-back, requester 1: 0x205 then 0x300 → `rsp1_valid` pulses with `rsp1_data` = 0xA5 three cycles after the 0x300 accept. `rsp0_valid` stays 0.
- Contention right after reset: both requesters hold 00-commands → requester 0 granted first. `req1_ready` = 0 until requester 0 completes with 01, then requester 1 is granted.
- Round robin: after requester 0 completes, both valid in IDLE → requester 1 wins. On the next contention → requester 0 wins.
- Timeout with `TIMEOUT` = 8: requester 0 sends 0x005 then stalls while requester 1 is valid → exactly 8 cycles later `timeout_evt` pulses, the state returns to IDLE, and requester 1 is accepted on the following edge.
- Reset in RD_WAIT: `rst` pulse the cycle after a 11 accept, with `ram_tx_valid` arriving afterwards → no `rsp_valid`, all outputs 0, state IDLE.
